// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes, stop-bit encoding
// and the parity-error rule, used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_t;

  localparam int PAR_NONE  = 0;
  localparam int PAR_EVEN  = 1;
  localparam int PAR_ODD   = 2;
  localparam int PAR_MARK  = 3;
  localparam int PAR_SPACE = 4;

  localparam int STOP_1 = 0;
  localparam int STOP_2 = 1;

  // data_xor is the XOR of all data bits, p the received parity bit.
  function automatic logic parity_error(input int mode, input logic data_xor, input logic p);
    case (mode)
      PAR_EVEN:  return data_xor ^ p;
      PAR_ODD:   return ~(data_xor ^ p);
      PAR_MARK:  return ~p;
      PAR_SPACE: return p;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous input that idles high;
// both flops reset to 1 so a reset never looks like a falling edge.
module uart_sync (
  input  logic clk,
  input  logic nrst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with centre sampling and per-frame error flags.
// Define UART_RX_MAJORITY_EN to take each bit as a 2-of-3 vote around the centre.
module uart_rx
  import uart_pkg::*;
#(
  parameter int N      = 8,
  parameter int M      = 3,
  parameter int OVS    = 16,
  parameter int PARITY = 0,
  parameter int STOP   = 0
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         rx,
  output logic [N-1:0] data,
  output logic         valid,
  output logic         parity_err,
  output logic         frame_err,
  output logic         busy
);

  // Output handshake: valid is a one-cycle pulse with no backpressure; data,
  // parity_err and frame_err are valid in that cycle and hold until the next one.

  localparam int OS_W = $clog2(OVS);
`ifdef UART_RX_MAJORITY_EN
  localparam int START_PT = OVS / 2;
`else
  localparam int START_PT = OVS / 2 - 1;
`endif
  localparam logic [OS_W-1:0] OS_START  = OS_W'(START_PT);
  localparam logic [OS_W-1:0] OS_LAST   = OS_W'(OVS - 1);
  localparam logic [M-1:0]    BIT_LAST  = M'(N - 1);
  localparam logic [M-1:0]    STOP_LAST = M'(STOP);

  uart_state_t     state;
  logic            rx_s;
  logic            bit_s;
  logic            armed;
  logic [OS_W-1:0] os_cnt;
  logic [M-1:0]    bit_cnt;
  logic [N-1:0]    shreg;
  logic            par_cand;
  logic            ferr_cand;
  logic            centre;
  logic            stop_bad;

  uart_sync u_sync (
    .clk  (clk),
    .nrst (nrst),
    .d    (rx),
    .q    (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // hist[0] is rx_s one cycle ago, hist[1] two cycles ago; every decision point
  // is shifted one cycle late so the vote spans centre-1 .. centre+1.
  logic [1:0] hist;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) hist <= 2'b11;
    else       hist <= {hist[0], rx_s};
  end

  assign bit_s = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  assign bit_s = rx_s;
`endif

  assign centre   = (os_cnt == OS_LAST);
  assign stop_bad = ferr_cand | ~bit_s;
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= S_IDLE;
      armed      <= 1'b0;
      os_cnt     <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_cand   <= 1'b0;
      ferr_cand  <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_s) armed <= 1'b1;
          if (armed && !rx_s) begin
            state     <= S_START;
            os_cnt    <= '0;
            bit_cnt   <= '0;
            par_cand  <= 1'b0;
            ferr_cand <= 1'b0;
          end
        end
        S_START: begin
          if (os_cnt == OS_START) begin
            os_cnt <= '0;
            state  <= bit_s ? S_IDLE : S_DATA;
          end else begin
            os_cnt <= os_cnt + OS_W'(1);
          end
        end
        S_DATA: begin
          if (centre) begin
            os_cnt <= '0;
            shreg  <= {shreg[N-2:0], bit_s};
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              state   <= (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + M'(1);
            end
          end else begin
            os_cnt <= os_cnt + OS_W'(1);
          end
        end
        S_PARITY: begin
          if (centre) begin
            os_cnt   <= '0;
            par_cand <= parity_error(PARITY, ^shreg, bit_s);
            state    <= S_STOP;
          end else begin
            os_cnt <= os_cnt + OS_W'(1);
          end
        end
        S_STOP: begin
          if (centre) begin
            os_cnt <= '0;
            if (bit_cnt == STOP_LAST) begin
              // Leave at mid-stop so the next start edge is caught on time.
              data       <= shreg;
              valid      <= 1'b1;
              parity_err <= par_cand;
              frame_err  <= stop_bad;
              state      <= S_IDLE;
              if (stop_bad) armed <= 1'b0;
            end else begin
              bit_cnt   <= bit_cnt + M'(1);
              ferr_cand <= stop_bad;
            end
          end else begin
            os_cnt <= os_cnt + OS_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: three instances (default, even parity, two stop
// bits) on separate serial lines, a scoreboard of expected frames and a summary.
module tb_uart_rx;

  localparam int OVS = 16;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
  logic [7:0] data0, data1, data2;
  logic valid0, valid1, valid2;
  logic parity_err0, parity_err1, parity_err2;
  logic frame_err0, frame_err1, frame_err2;
  logic busy0, busy1, busy2;

  uart_rx dut0 (
    .clk(clk), .nrst(nrst), .rx(rx0), .data(data0), .valid(valid0),
    .parity_err(parity_err0), .frame_err(frame_err0), .busy(busy0)
  );

  uart_rx #(.PARITY(1)) dut1 (
    .clk(clk), .nrst(nrst), .rx(rx1), .data(data1), .valid(valid1),
    .parity_err(parity_err1), .frame_err(frame_err1), .busy(busy1)
  );

  uart_rx #(.STOP(1)) dut2 (
    .clk(clk), .nrst(nrst), .rx(rx2), .data(data2), .valid(valid2),
    .parity_err(parity_err2), .frame_err(frame_err2), .busy(busy2)
  );

  // scoreboard: record = {id[1:0], parity_err, frame_err, data[7:0]}
  logic [11:0] exp_q[$];
  logic [11:0] cap_q[$];
  int          cap_cyc[$];
  int          n_checks = 0;
  int          n_pass = 0;

  always @(negedge clk) begin
    if (valid0) begin cap_q.push_back({2'd0, parity_err0, frame_err0, data0}); cap_cyc.push_back(cyc); end
    if (valid1) begin cap_q.push_back({2'd1, parity_err1, frame_err1, data1}); cap_cyc.push_back(cyc); end
    if (valid2) begin cap_q.push_back({2'd2, parity_err2, frame_err2, data2}); cap_cyc.push_back(cyc); end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // driver tasks
  task automatic set_rx(input int id, input logic v);
    case (id)
      0: rx0 = v;
      1: rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  task automatic send_bit(input int id, input logic v);
    set_rx(id, v);
    repeat (OVS) @(negedge clk);
  endtask

  task automatic send_frame(input int id, input logic [7:0] d, input logic par_en,
                            input logic p, input logic stop_v, input int nstop);
    send_bit(id, 1'b0);
    for (int i = 7; i >= 0; i--) send_bit(id, d[i]);
    if (par_en) send_bit(id, p);
    for (int s = 0; s < nstop; s++) send_bit(id, stop_v);
  endtask

  task automatic expect_frame(input logic [1:0] id, input logic perr, input logic ferr,
                              input logic [7:0] d);
    exp_q.push_back({id, perr, ferr, d});
  endtask

  task automatic drain(input string tag);
    check({tag, "_count"}, cap_q.size(), exp_q.size());
    while (cap_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_frame"}, cap_q.pop_front(), exp_q.pop_front());
    cap_q.delete();
    exp_q.delete();
    cap_cyc.delete();
  endtask

  initial begin
    int c0;
    int bc;

    repeat (3) @(negedge clk);
    check("rst_data", data0, 8'h00);
    check("rst_valid", valid0, 1'b0);
    check("rst_perr", parity_err0, 1'b0);
    check("rst_ferr", frame_err0, 1'b0);
    check("rst_busy", busy0, 1'b0);
    nrst = 1'b1;
    repeat (20) @(negedge clk);

    // 0xA5, 8N1: valid 11 + 16*9 cycles after the start edge is driven
    c0 = cyc;
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, 1);
    repeat (8) @(negedge clk);
    check("a5_latency", (cap_cyc.size() > 0) ? cap_cyc[0] - c0 : -1, 11 + 16 * 9 + MAJ);
    expect_frame(2'd0, 1'b0, 1'b0, 8'hA5);
    drain("a5");

    // 4-cycle low glitch: START for OVS/2 cycles then back to IDLE
    bc = 0;
    set_rx(0, 1'b0);
    for (int i = 0; i < 44; i++) begin
      if (i == 4) set_rx(0, 1'b1);
      @(negedge clk);
      if (busy0) bc++;
    end
    check("glitch_busy_cycles", bc, 8 + MAJ);
    check("glitch_busy_bound", (bc <= OVS / 2 + 2), 1'b1);
    drain("glitch");

    // even parity on 0x03: parity bit 1 is wrong, 0 is right
    send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1, 1);
    repeat (8) @(negedge clk);
    expect_frame(2'd1, 1'b1, 1'b0, 8'h03);
    drain("par_bad");
    send_frame(1, 8'h03, 1'b1, 1'b0, 1'b1, 1);
    repeat (8) @(negedge clk);
    expect_frame(2'd1, 1'b0, 1'b0, 8'h03);
    drain("par_good");

    // 0x55 with a 0 stop bit, then a 40-bit break, then a clean 0x3C
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0, 1);
    repeat (20 * OVS) @(negedge clk);
    check("brk_idle", busy0, 1'b0);
    repeat (20 * OVS) @(negedge clk);
    set_rx(0, 1'b1);
    repeat (2 * OVS) @(negedge clk);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, 1);
    repeat (8) @(negedge clk);
    expect_frame(2'd0, 1'b0, 1'b1, 8'h55);
    expect_frame(2'd0, 1'b0, 1'b0, 8'h3C);
    drain("brk");

    // reset in data bit 4 of 0x0F: the rest of the line stays high
    fork
      send_frame(0, 8'h0F, 1'b0, 1'b0, 1'b1, 1);
      begin
        repeat (OVS * 5 + 8) @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        check("mid_rst_data", data0, 8'h00);
        check("mid_rst_valid", valid0, 1'b0);
        check("mid_rst_busy", busy0, 1'b0);
        check("mid_rst_perr", parity_err0, 1'b0);
        check("mid_rst_ferr", frame_err0, 1'b0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
      end
    join
    repeat (8) @(negedge clk);
    drain("rst_abort");
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, 1);
    repeat (8) @(negedge clk);
    expect_frame(2'd0, 1'b0, 1'b0, 8'h3C);
    drain("rst_next");

    // two stop bits, back-to-back 0x00 and 0xFF
    send_frame(2, 8'h00, 1'b0, 1'b0, 1'b1, 2);
    send_frame(2, 8'hFF, 1'b0, 1'b0, 1'b1, 2);
    repeat (8) @(negedge clk);
    expect_frame(2'd2, 1'b0, 1'b0, 8'h00);
    expect_frame(2'd2, 1'b0, 1'b0, 8'hFF);
    drain("b2b");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
